// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared types and constants for the SRAM port arbiter
package sram_arb_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_state_e;

    localparam logic [3:0] WSTRB_READ = 4'b0000;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
    endfunction

    function automatic lock_state_e lock_of(input owner_e o);
        return (o == OWNER_DATA) ? LOCK_DATA : LOCK_INST;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - SRAM-like req/addr_ok/data_ok port bundle
interface sram_port_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;

    modport master (
        output req, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_port_arbiter_owner_fifo.sv
// rtl/sram_port_arbiter_owner_fifo.sv - in-order owner FIFO of accepted, unanswered transactions
module sram_arb_owner_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   resetn,
    input  logic   i_push,
    input  owner_e i_push_owner,
    input  logic   i_pop,
    output owner_e o_head,
    output logic   o_full,
    output logic   o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    owner_e           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_owner;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM-like port between IF and MEM masters
// Define SRAM_ARB_RR_EN for round-robin contention instead of fixed data priority.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32
) (
    input  logic        clk,
    input  logic        resetn,
    sram_port_if.slave  inst_if,
    sram_port_if.slave  data_if,
    sram_port_if.master sram_if
);
    lock_state_e       r_state;
    lock_state_e       w_state_nxt;
    owner_e            w_prefer;
    owner_e            w_arb_pick;
    owner_e            w_grant;
    owner_e            w_head;
    logic              w_sram_req;
    logic              w_accept;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_fwd_addr;

`ifdef SRAM_ARB_RR_EN
    owner_e r_rr_prefer;

    // The winner of any accept yields the next contended cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_prefer <= OWNER_DATA;
        end else if (w_accept) begin
            r_rr_prefer <= other_owner(w_grant);
        end
    end

    assign w_prefer = r_rr_prefer;
`else
    assign w_prefer = OWNER_DATA;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= LOCK_NONE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A presented-but-unaccepted request keeps its master until taken or withdrawn.
    always_comb begin
        w_arb_pick  = w_prefer;
        w_grant     = OWNER_DATA;
        w_sram_req  = 1'b0;
        w_accept    = 1'b0;
        w_state_nxt = LOCK_NONE;

        if (!(inst_if.req && data_if.req)) begin
            w_arb_pick = data_if.req ? OWNER_DATA : OWNER_INST;
        end

        w_grant = w_arb_pick;
        case (r_state)
            LOCK_INST: if (inst_if.req) w_grant = OWNER_INST;
            LOCK_DATA: if (data_if.req) w_grant = OWNER_DATA;
            default:   ;
        endcase

        w_sram_req = resetn & (inst_if.req | data_if.req) & ~w_full;
        w_accept   = w_sram_req & sram_if.addr_ok;

        if (w_sram_req && !sram_if.addr_ok) begin
            w_state_nxt = lock_of(w_grant);
        end
    end

    sram_arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .i_push       (w_accept),
        .i_push_owner (w_grant),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    assign w_fwd_addr    = (w_grant == OWNER_DATA) ? data_if.addr : inst_if.addr;

    assign sram_if.req   = w_sram_req;
    assign sram_if.addr  = w_fwd_addr;
    assign sram_if.wstrb = (w_grant == OWNER_DATA) ? data_if.wstrb : WSTRB_READ;
    assign sram_if.wdata = (w_grant == OWNER_DATA) ? data_if.wdata : 32'h0;

    assign inst_if.addr_ok = w_accept & (w_grant == OWNER_INST);
    assign data_if.addr_ok = w_accept & (w_grant == OWNER_DATA);

    // Responses with nothing outstanding are dropped rather than misrouted.
    assign w_pop           = resetn & sram_if.data_ok & ~w_empty;
    assign inst_if.data_ok = w_pop & (w_head == OWNER_INST);
    assign data_if.data_ok = w_pop & (w_head == OWNER_DATA);
    assign inst_if.rdata   = sram_if.rdata;
    assign data_if.rdata   = sram_if.rdata;
endmodule
